// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the audio record/playback controller.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    PLAY  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int SAMPLE_W  = 16;
  localparam int LED_W     = 10;
  localparam int LED_REC   = 9;
  localparam int LED_PLAY  = 8;
  localparam int LED_OVR   = 7;
  localparam int LED_UDR   = 6;
  localparam int LED_PTR_W = 6;

endpackage

// File: rtl/audio_edge_pulse.sv
// Registers a level input and emits a one-cycle pulse on its rising edge.
module audio_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;
  logic in_d;
  logic prev_q;
  logic prev_d;

  always_comb begin
    in_d   = in_i;
    prev_d = in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      in_q   <= in_d;
      prev_q <= prev_d;
    end
  end

  assign pulse_o = in_q & ~prev_q;

endmodule

// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer: codec samples to and from one SDRAM buffer
// through an Avalon-MM master with a single outstanding transaction.
module audio_rec_play_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MAX_SAMPLES = 4194304
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                sync_in,
  input  logic [SAMPLE_W-1:0] data_in,
  output logic [SAMPLE_W-1:0] data_out,
  input  logic                record_btn_in,
  input  logic                play_btn_in,
  output logic [LED_W-1:0]    led_out,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [SAMPLE_W-1:0] avm_writedata,
  output logic                avm_read,
  input  logic [SAMPLE_W-1:0] avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [PTR_W-1:0] MAX_P = PTR_W'(MAX_SAMPLES);
  localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);

  logic sync_p;
  logic rec_p;
  logic play_p;

  audio_edge_pulse u_sync (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .in_i    (sync_in),
    .pulse_o (sync_p)
  );

  audio_edge_pulse u_rec (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .in_i    (record_btn_in),
    .pulse_o (rec_p)
  );

  audio_edge_pulse u_play (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .in_i    (play_btn_in),
    .pulse_o (play_p)
  );

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    rec_len_q, rec_len_d;
  logic                ovr_q, ovr_d;
  logic                udr_q, udr_d;
  logic                write_q, write_d;
  logic                read_q, read_d;
  logic                rd_wait_q, rd_wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] wdata_q, wdata_d;
  logic [SAMPLE_W-1:0] dout_q, dout_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             rd_done;
  logic             wr_last;
  logic             rd_last;
  logic             pend_next;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W-1:0] rd_ptr_inc;

  always_comb begin
    wr_ptr_inc = wr_ptr_q + ONE_P;
    rd_ptr_inc = rd_ptr_q + ONE_P;
    wr_acc     = write_q & ~avm_waitrequest;
    rd_acc     = read_q & ~avm_waitrequest;
    rd_done    = rd_wait_q & avm_readdatavalid;
    wr_last    = wr_acc & (wr_ptr_inc == MAX_P);
    rd_last    = rd_done & (rd_ptr_inc == rec_len_q);
    // still busy after this edge: stalled write, any read not yet returned
    pend_next  = (write_q & avm_waitrequest) | read_q
               | (rd_wait_q & ~avm_readdatavalid);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rec_len_q <= '0;
      ovr_q     <= 1'b0;
      udr_q     <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      rd_wait_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rec_len_q <= rec_len_d;
      ovr_q     <= ovr_d;
      udr_q     <= udr_d;
      write_q   <= write_d;
      read_q    <= read_d;
      rd_wait_q <= rd_wait_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rec_p) begin
          state_d = REC;
        end else if (play_p && rec_len_q != '0) begin
          state_d = PLAY;
        end
      end
      REC: begin
        if (wr_last) begin
          state_d = IDLE;
        end else if (rec_p) begin
          state_d = pend_next ? DRAIN : IDLE;
        end
      end
      PLAY: begin
        if (rd_last) begin
          state_d = IDLE;
        end else if (play_p) begin
          state_d = pend_next ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!pend_next) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rec_len_d = rec_len_q;
    ovr_d     = ovr_q;
    udr_d     = udr_q;
    write_d   = write_q;
    read_d    = read_q;
    rd_wait_d = rd_wait_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;

    if (state_q == IDLE && state_d == REC) begin
      wr_ptr_d  = '0;
      rec_len_d = '0;
      ovr_d     = 1'b0;
    end
    if (state_q == IDLE && state_d == PLAY) begin
      rd_ptr_d = '0;
      udr_d    = 1'b0;
    end

    if (wr_acc) begin
      write_d   = 1'b0;
      wr_ptr_d  = wr_ptr_inc;
      rec_len_d = wr_ptr_inc;
    end
    if (state_q == REC && state_d == REC && sync_p) begin
      if (write_q) begin
        ovr_d = 1'b1;
      end else begin
        write_d = 1'b1;
        addr_d  = BASE + wr_ptr_q[ADDR_W-1:0];
        wdata_d = data_in;
      end
    end

    if (rd_acc) begin
      read_d    = 1'b0;
      rd_wait_d = 1'b1;
    end
    if (rd_done) begin
      rd_wait_d = 1'b0;
      rd_ptr_d  = rd_ptr_inc;
      if (state_q == PLAY) begin
        dout_d = avm_readdata;
      end
    end
    if (state_q == PLAY && state_d == PLAY && sync_p) begin
      if (read_q || rd_wait_q) begin
        udr_d = 1'b1;
      end else begin
        read_d = 1'b1;
        addr_d = BASE + rd_ptr_q[ADDR_W-1:0];
      end
    end

    // the final sample stays visible for one cycle before the output clears
    if (state_d != PLAY && !(rd_last && state_q == PLAY)) begin
      dout_d = '0;
    end
  end

  logic [LED_W-1:0] led_d;

  always_comb begin
    led_d           = '0;
    led_d[LED_REC]  = (state_q == REC);
    led_d[LED_PLAY] = (state_q == PLAY) || (state_q == DRAIN);
    led_d[LED_OVR]  = ovr_q;
    led_d[LED_UDR]  = udr_q;
    if (state_q == REC) begin
      led_d[LED_PTR_W-1:0] = wr_ptr_q[ADDR_W-1 -: LED_PTR_W];
    end else if (state_q == PLAY) begin
      led_d[LED_PTR_W-1:0] = rd_ptr_q[ADDR_W-1 -: LED_PTR_W];
    end
  end

  assign led_out       = led_d;
  assign avm_address   = addr_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign avm_read      = read_q;
  assign data_out      = dout_q;

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Directed bench for audio_rec_play_ctrl with a small Avalon slave model.
module tb_audio_rec_play_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sync_in = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        rec_btn = 1'b0;
  logic        play_btn = 1'b0;
  logic [9:0]  led;
  logic [21:0] addr;
  logic        wr;
  logic [15:0] wdata;
  logic        rd;
  logic [15:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        wreq = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [0:63];
  logic [21:0] wa_q [$];
  logic [15:0] wd_q [$];
  logic        acc_r;
  logic [21:0] acc_a;

  audio_rec_play_ctrl dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .sync_in           (sync_in),
    .data_in           (data_in),
    .data_out          (data_out),
    .record_btn_in     (rec_btn),
    .play_btn_in       (play_btn),
    .led_out           (led),
    .avm_address       (addr),
    .avm_write         (wr),
    .avm_writedata     (wdata),
    .avm_read          (rd),
    .avm_readdata      (rdata),
    .avm_readdatavalid (rvalid),
    .avm_waitrequest   (wreq)
  );

  always #5 clk = ~clk;

  // slave: read data returns one cycle after acceptance
  always @(negedge clk) begin
    acc_r = rd && !wreq;
    acc_a = addr;
    if (wr && !wreq) begin
      mem[addr[5:0]] = wdata;
      wa_q.push_back(addr);
      wd_q.push_back(wdata);
    end
    @(posedge clk);
    #1;
    rvalid = acc_r;
    rdata  = acc_r ? mem[acc_a[5:0]] : 16'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_edge(input logic [15:0] d);
    data_in = d;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    tick();
  endtask

  task automatic press_rec();
    rec_btn = 1'b1;
    tick();
    rec_btn = 1'b0;
    tick();
  endtask

  task automatic press_play();
    play_btn = 1'b1;
    tick();
    play_btn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_write got=%0b exp=0", wr);
    end
    total++;
    if (rd !== 1'b0) begin
      bad++;
      $display("FAIL reset_read got=%0b exp=0", rd);
    end
    total++;
    if (data_out !== 16'h0) begin
      bad++;
      $display("FAIL reset_dout got=%0h exp=0", data_out);
    end
    total++;
    if (led !== 10'h0) begin
      bad++;
      $display("FAIL reset_led got=%0h exp=0", led);
    end
    total++;
    if (addr !== 22'h0) begin
      bad++;
      $display("FAIL reset_addr got=%0h exp=0", addr);
    end
    total++;
    if (wdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_wdata got=%0h exp=0", wdata);
    end
  endtask

  task automatic test_record();
    wa_q.delete();
    wd_q.delete();
    wreq = 1'b0;
    press_rec();
    total++;
    if (led[9] !== 1'b1) begin
      bad++;
      $display("FAIL rec_led9 got=%0b exp=1", led[9]);
    end
    for (int i = 1; i <= 4; i++) begin
      sync_edge(16'(i));
      total++;
      if (wr !== 1'b1 || addr !== 22'(i - 1) || wdata !== 16'(i)) begin
        bad++;
        $display("FAIL rec_write%0d got=%0b/%0h/%0h exp=1/%0h/%0h",
                 i, wr, addr, wdata, i - 1, i);
      end
      tick();
    end
    press_rec();
    total++;
    if (led[9] !== 1'b0) begin
      bad++;
      $display("FAIL rec_stop_led9 got=%0b exp=0", led[9]);
    end
    total++;
    if (wa_q.size() != 4) begin
      bad++;
      $display("FAIL rec_count got=%0d exp=4", wa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wa_q[i] !== 22'(i) || wd_q[i] !== 16'(i + 1)) begin
          bad++;
          $display("FAIL rec_log%0d got=%0h/%0h exp=%0h/%0h",
                   i, wa_q[i], wd_q[i], i, i + 1);
        end
      end
    end
  endtask

  task automatic test_playback();
    press_play();
    total++;
    if (led[8] !== 1'b1) begin
      bad++;
      $display("FAIL play_led8 got=%0b exp=1", led[8]);
    end
    for (int i = 1; i <= 4; i++) begin
      sync_edge(16'h0);
      total++;
      if (rd !== 1'b1 || addr !== 22'(i - 1)) begin
        bad++;
        $display("FAIL play_read%0d got=%0b/%0h exp=1/%0h",
                 i, rd, addr, i - 1);
      end
      tick();
      tick();
      total++;
      if (data_out !== 16'(i)) begin
        bad++;
        $display("FAIL play_dout%0d got=%0h exp=%0h", i, data_out, i);
      end
    end
    total++;
    if (led[8] !== 1'b0) begin
      bad++;
      $display("FAIL play_end_led8 got=%0b exp=0", led[8]);
    end
    tick();
    total++;
    if (data_out !== 16'h0) begin
      bad++;
      $display("FAIL play_end_dout got=%0h exp=0", data_out);
    end
  endtask

  task automatic test_stall();
    wa_q.delete();
    wd_q.delete();
    wreq = 1'b0;
    press_rec();
    sync_edge(16'h00a1);
    tick();
    wreq = 1'b1;
    sync_edge(16'h00a2);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (wr !== 1'b1 || addr !== 22'h1 || wdata !== 16'h00a2) begin
        bad++;
        $display("FAIL stall_hold%0d got=%0b/%0h/%0h exp=1/1/a2",
                 k, wr, addr, wdata);
      end
      if (k == 3) begin
        total++;
        if (led[9:8] !== 2'b01) begin
          bad++;
          $display("FAIL stall_drain got=%0b exp=01", led[9:8]);
        end
      end
      if (k == 1) rec_btn = 1'b1;
      if (k == 2) rec_btn = 1'b0;
      tick();
    end
    wreq = 1'b0;
    tick();
    total++;
    if (wr !== 1'b0 || led[9:8] !== 2'b00) begin
      bad++;
      $display("FAIL stall_idle got=%0b/%0b exp=0/00", wr, led[9:8]);
    end
    total++;
    if (wa_q.size() != 2) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=2", wa_q.size());
    end else begin
      total++;
      if (wa_q[1] !== 22'h1 || wd_q[1] !== 16'h00a2) begin
        bad++;
        $display("FAIL stall_log got=%0h/%0h exp=1/a2", wa_q[1], wd_q[1]);
      end
    end
    press_play();
    sync_edge(16'h0);
    tick();
    tick();
    total++;
    if (data_out !== 16'h00a1) begin
      bad++;
      $display("FAIL stall_pb0 got=%0h exp=a1", data_out);
    end
    sync_edge(16'h0);
    tick();
    tick();
    total++;
    if (data_out !== 16'h00a2 || led[8] !== 1'b0) begin
      bad++;
      $display("FAIL stall_pb1 got=%0h/%0b exp=a2/0", data_out, led[8]);
    end
    tick();
  endtask

  task automatic test_overrun();
    wa_q.delete();
    wd_q.delete();
    press_rec();
    wreq = 1'b1;
    sync_edge(16'h00b1);
    total++;
    if (wr !== 1'b1 || addr !== 22'h0) begin
      bad++;
      $display("FAIL ovr_first got=%0b/%0h exp=1/0", wr, addr);
    end
    sync_edge(16'h00b2);
    total++;
    if (led[7] !== 1'b1) begin
      bad++;
      $display("FAIL ovr_flag got=%0b exp=1", led[7]);
    end
    total++;
    if (wdata !== 16'h00b1 || addr !== 22'h0) begin
      bad++;
      $display("FAIL ovr_hold got=%0h/%0h exp=b1/0", wdata, addr);
    end
    wreq = 1'b0;
    tick();
    sync_edge(16'h00b3);
    total++;
    if (addr !== 22'h1 || wdata !== 16'h00b3) begin
      bad++;
      $display("FAIL ovr_next got=%0h/%0h exp=1/b3", addr, wdata);
    end
    tick();
    press_rec();
    total++;
    if (wa_q.size() != 2) begin
      bad++;
      $display("FAIL ovr_count got=%0d exp=2", wa_q.size());
    end else begin
      total++;
      if (wa_q[1] !== 22'h1 || wd_q[1] !== 16'h00b3) begin
        bad++;
        $display("FAIL ovr_log got=%0h/%0h exp=1/b3", wa_q[1], wd_q[1]);
      end
    end
    press_rec();
    total++;
    if (led[9] !== 1'b1 || led[7] !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear got=%0b/%0b exp=1/0", led[9], led[7]);
    end
    press_rec();
  endtask

  task automatic test_priority();
    press_play();
    total++;
    if (led[8] !== 1'b0) begin
      bad++;
      $display("FAIL prio_empty_play got=%0b exp=0", led[8]);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd !== 1'b0) begin
        bad++;
        $display("FAIL prio_no_read%0d got=%0b exp=0", k, rd);
      end
      tick();
    end
    rec_btn = 1'b1;
    play_btn = 1'b1;
    tick();
    rec_btn = 1'b0;
    play_btn = 1'b0;
    tick();
    total++;
    if (led[9:8] !== 2'b10) begin
      bad++;
      $display("FAIL prio_rec_wins got=%0b exp=10", led[9:8]);
    end
    press_rec();
    total++;
    if (led[9] !== 1'b0) begin
      bad++;
      $display("FAIL prio_stop got=%0b exp=0", led[9]);
    end
  endtask

  task automatic test_reset_mid_read();
    wreq = 1'b0;
    press_rec();
    sync_edge(16'h00c1);
    tick();
    sync_edge(16'h00c2);
    tick();
    press_rec();
    press_play();
    sync_edge(16'h0);
    tick();
    tick();
    total++;
    if (data_out !== 16'h00c1) begin
      bad++;
      $display("FAIL rmr_dout got=%0h exp=c1", data_out);
    end
    wreq = 1'b1;
    sync_edge(16'h0);
    total++;
    if (rd !== 1'b1 || addr !== 22'h1) begin
      bad++;
      $display("FAIL rmr_read got=%0b/%0h exp=1/1", rd, addr);
    end
    sync_edge(16'h0);
    total++;
    if (led[6] !== 1'b1 || data_out !== 16'h00c1) begin
      bad++;
      $display("FAIL rmr_udr got=%0b/%0h exp=1/c1", led[6], data_out);
    end
    rst = 1'b1;
    tick();
    total++;
    if (rd !== 1'b0 || data_out !== 16'h0 || led !== 10'h0) begin
      bad++;
      $display("FAIL rmr_reset got=%0b/%0h/%0h exp=0/0/0",
               rd, data_out, led);
    end
    rst = 1'b0;
    wreq = 1'b0;
    press_play();
    total++;
    if (led[8] !== 1'b0) begin
      bad++;
      $display("FAIL rmr_len_clr got=%0b exp=0", led[8]);
    end
    tick();
    total++;
    if (rd !== 1'b0) begin
      bad++;
      $display("FAIL rmr_no_read got=%0b exp=0", rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    test_reset();
    test_record();
    test_playback();
    test_stall();
    test_overrun();
    test_priority();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
